round_robin_arbiter_with_bursts: RTL

- Shares one downstream resource among N requesters in round-robin order.
- Unlike a single-cycle arbiter, a grant is held for a whole multi-beat burst.
- A burst ends on the requester's last beat, when the requester drops its request, or at a MAX_BEATS fairness limit.
- Sits between N producer ports and a single shared sink that has a ready signal.

---
 rtl/arb_pkg.sv | 16 +
 rtl/rr_priority_picker.sv | 47 ++++
 rtl/round_robin_arbiter_with_bursts.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and width helpers for the burst round-robin arbiter.
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    // Width of a binary index into n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a beat counter that must be able to hold the value max_beats.
    function automatic int cnt_width(input int max_beats);
        return (max_beats > 0) ? $clog2(max_beats + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Circular first-set-bit finder: returns the first requester at or after
// start, wrapping past N-1 back to 0.
module rr_priority_picker
    import arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] offset;
    logic [IDX_W:0]   sum;

    // Rotate so that bit 0 of rot is requester 'start'; the double-width
    // copy supplies the wrapped-around bits.
    assign dbl = {req, req} >> start;
    assign rot = dbl[N-1:0];

    // Priority-encode the rotated vector (lowest bit wins), then map the
    // offset back to an absolute requester index modulo N.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        found  = 1'b0;
        offset = '0;
        sum    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found  = 1'b1;
                offset = IDX_W'(i);
            end
        end
        sum = {1'b0, start} + {1'b0, offset};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/round_robin_arbiter_with_bursts.sv
// Round-robin arbiter that holds each grant for a whole burst: until the
// owner's last beat, the owner dropping its request, or MAX_BEATS beats.
module round_robin_arbiter_with_bursts
    import arb_pkg::*;
#(
    parameter  int N         = 4,
    parameter  int MAX_BEATS = 8,
    localparam int IDX_W     = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     requests,
    input  logic [N-1:0]     last,
    input  logic             ready,
    output logic [N-1:0]     grants,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             beat
);

    localparam int CNT_W = cnt_width(MAX_BEATS);

    arb_state_t       state, state_nxt;
    logic [N-1:0]     grants_nxt;
    logic             grant_valid_nxt;
    logic [IDX_W-1:0] grant_idx_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [IDX_W-1:0] owner_next;
    logic [IDX_W-1:0] pick_start;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_req;
    logic             owner_last;
    logic             at_limit;
    logic             release_now;

    // Requester after the current owner; it becomes both the new priority
    // pointer and the search start on release, putting the owner last.
    assign owner_next = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);

    // One picker serves both paths: from ptr when idle, from owner+1 on release.
    assign pick_start = (state == ARB_BUSY) ? owner_next : ptr;

    rr_priority_picker #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (requests),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_req  = requests[grant_idx];
    assign owner_last = last[grant_idx];
    assign beat       = grant_valid & owner_req & ready;

    // This beat would be the MAX_BEATS-th accepted beat of the burst.
    assign at_limit = (cnt == CNT_W'(MAX_BEATS - 1));

    // Burst ends on the last beat, at the fairness limit, or on an abort.
    assign release_now = (state == ARB_BUSY) &&
                         (!owner_req || (beat && (owner_last || at_limit)));

    // Next-state and next-output logic for the IDLE/BUSY controller.
    always_comb begin
        state_nxt       = state;
        grants_nxt      = grants;
        grant_valid_nxt = grant_valid;
        grant_idx_nxt   = grant_idx;
        ptr_nxt         = ptr;
        cnt_nxt         = cnt;

        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_nxt            = ARB_BUSY;
                    grants_nxt           = '0;
                    grants_nxt[pick_idx] = 1'b1;
                    grant_valid_nxt      = 1'b1;
                    grant_idx_nxt        = pick_idx;
                    cnt_nxt              = '0;
                end else begin
                    grants_nxt      = '0;
                    grant_valid_nxt = 1'b0;
                    grant_idx_nxt   = '0;
                    cnt_nxt         = '0;
                end
            end

            ARB_BUSY: begin
                if (release_now) begin
                    ptr_nxt = owner_next;
                    cnt_nxt = '0;
                    if (pick_found) begin
                        // Back-to-back handover, no idle bubble.
                        grants_nxt           = '0;
                        grants_nxt[pick_idx] = 1'b1;
                        grant_valid_nxt      = 1'b1;
                        grant_idx_nxt        = pick_idx;
                    end else begin
                        state_nxt       = ARB_IDLE;
                        grants_nxt      = '0;
                        grant_valid_nxt = 1'b0;
                        grant_idx_nxt   = '0;
                    end
                end else if (beat && (cnt != CNT_W'(MAX_BEATS))) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt       = ARB_IDLE;
                grants_nxt      = '0;
                grant_valid_nxt = 1'b0;
                grant_idx_nxt   = '0;
                cnt_nxt         = '0;
            end
        endcase
    end

    // State, pointer, counter and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state       <= ARB_IDLE;
            grants      <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            ptr         <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_nxt;
            grants      <= grants_nxt;
            grant_valid <= grant_valid_nxt;
            grant_idx   <= grant_idx_nxt;
            ptr         <= ptr_nxt;
            cnt         <= cnt_nxt;
        end
    end

endmodule
